mem_port_arbiter: RTL

Two-requester arbiter and sequencer for the single shared memory port. Requester 0 is instruction fetch; requester 1 is the load/store unit. The block grants the port round-robin and drives the address/data select muxes in front of memory. It holds each access for a fixed memory latency, then returns a one-cycle acknowledge with read data.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_mux2_w.sv | 13 +
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and the round-robin pick for the memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned AW_DEF  = 16;
  localparam int unsigned DW_DEF  = 16;
  localparam int unsigned LAT_DEF = 2;
  localparam int unsigned CNT_W   = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Single request wins outright; a tie goes to whoever was not served last.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    return (r0 && r1) ? ~last : r1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_mux2_w.sv
// Parameterised-width 2:1 select mux in front of the memory port.
module mux2_w #(
  parameter int unsigned W = 1
) (
  input  logic         sel_i,
  input  logic [W-1:0] in0_i,
  input  logic [W-1:0] in1_i,
  output logic [W-1:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer for the shared memory port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned LAT = LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          sel,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]       state_q, state_d;
  logic             g_q, g_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic [0:0]       mux_we;

  mux2_w #(.W(AW)) u_mux_addr (
    .sel_i (g_q),
    .in0_i (addr0),
    .in1_i (addr1),
    .out_o (mem_addr)
  );

  mux2_w #(.W(DW)) u_mux_wdata (
    .sel_i (g_q),
    .in0_i (wdata0),
    .in1_i (wdata1),
    .out_o (mem_wdata)
  );

  mux2_w #(.W(1)) u_mux_we (
    .sel_i (g_q),
    .in0_i (we0),
    .in1_i (we1),
    .out_o (mux_we)
  );

  // Decoded straight from the state register so reset deselects memory at once.
  assign mem_en = (state_q == ST_ACCESS);
  assign mem_we = mem_en & mux_we[0];

  assign sel   = g_q;
  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign busy  = busy_q;
  assign rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          g_d     = rr_pick(req0, req1, last_q);
          cnt_d   = CNT_W'(LAT - 1);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          if (!mux_we[0]) rdata_d = mem_rdata;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        last_d  = g_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ack0_d = (state_d == ST_DONE) && !g_q;
    ack1_d = (state_d == ST_DONE) &&  g_q;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

endmodule
